// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline sequencer: state encoding,
// the control-bundle struct and the canned control patterns.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic idex_load;
    logic exmem_load;
    logic memwb_load;
    logic ifid_clear;
    logic idex_clear;
    logic exmem_clear;
    logic memwb_clear;
  } pipe_ctl_t;

  // Everything held in reset, nothing loads.
  localparam pipe_ctl_t CTL_IDLE = '{
    pc_load: 1'b0, ifid_load: 1'b0, idex_load: 1'b0, exmem_load: 1'b0,
    memwb_load: 1'b0, ifid_clear: 1'b1, idex_clear: 1'b1, exmem_clear: 1'b1,
    memwb_clear: 1'b1
  };

  localparam pipe_ctl_t CTL_ADVANCE = '{
    pc_load: 1'b1, ifid_load: 1'b1, idex_load: 1'b1, exmem_load: 1'b1,
    memwb_load: 1'b1, ifid_clear: 1'b0, idex_clear: 1'b0, exmem_clear: 1'b0,
    memwb_clear: 1'b0
  };

  // Memory stall: hold every stage, push a bubble into WB.
  localparam pipe_ctl_t CTL_FREEZE = '{
    pc_load: 1'b0, ifid_load: 1'b0, idex_load: 1'b0, exmem_load: 1'b0,
    memwb_load: 1'b0, ifid_clear: 1'b0, idex_clear: 1'b0, exmem_clear: 1'b0,
    memwb_clear: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned RegAddrW = pipe_pkg::REG_ADDR_W,
  parameter int unsigned CntW     = pipe_pkg::CNT_W
);

  logic                start;
  logic                halt;
  logic [RegAddrW-1:0] id_rs;
  logic [RegAddrW-1:0] id_rt;
  logic                id_uses_rt;
  logic                ex_mem_read;
  logic [RegAddrW-1:0] ex_rd;
  logic                ex_branch_taken;
  logic                mem_busy;

  logic                pc_load;
  logic                ifid_load;
  logic                idex_load;
  logic                exmem_load;
  logic                memwb_load;
  logic                ifid_clear;
  logic                idex_clear;
  logic                exmem_clear;
  logic                memwb_clear;
  logic                running;
  logic                done;
  logic [CntW-1:0]     stall_cnt;
  logic [CntW-1:0]     flush_cnt;

  modport master (
    output start, halt, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           ifid_clear, idex_clear, exmem_clear, memwb_clear,
           running, done, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, halt, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           ifid_clear, idex_clear, exmem_clear, memwb_clear,
           running, done, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: start/halt/drain FSM plus stall, flush and freeze
// control of the PC and inter-stage registers, with statistics counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RegAddrW    = REG_ADDR_W,
  parameter int unsigned CntW        = CNT_W,
  parameter int unsigned DrainCycles = DRAIN_CYCLES
) (
  input logic         clock,
  input logic         clear_n,
  pipe_ctrl_if.slave  bus
);

  localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DrainCycles - 1);

  state_e            state_q;
  state_e            state_d;
  logic [DrainW-1:0] drain_q;
  logic [DrainW-1:0] drain_d;
  logic              done_q;
  logic              done_d;
  pipe_ctl_t         ctl;
  logic              hazard;
  logic              stall_inc;
  logic              flush_inc;
  logic              cnt_clr;
  logic [CntW-1:0]   stall_cnt;
  logic [CntW-1:0]   flush_cnt;

  // Load in EX feeding a source of the instruction in ID; r0 never hazards.
  assign hazard = bus.ex_mem_read && (bus.ex_rd != RegAddrW'(0)) &&
                  ((bus.ex_rd == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    ctl       = CTL_IDLE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.mem_busy) begin
          ctl       = CTL_FREEZE;
          stall_inc = 1'b1;
        end else if (bus.halt) begin
          ctl            = CTL_ADVANCE;
          ctl.pc_load    = 1'b0;
          ctl.ifid_load  = 1'b0;
          ctl.ifid_clear = 1'b1;
          state_d        = ST_DRAIN;
          drain_d        = DrainInit;
        end else if (bus.ex_branch_taken) begin
          ctl            = '0;
          ctl.pc_load    = 1'b1;
          ctl.ifid_clear = 1'b1;
          ctl.idex_clear = 1'b1;
          ctl.exmem_load = 1'b1;
          ctl.memwb_load = 1'b1;
          flush_inc      = 1'b1;
        end else if (hazard) begin
          ctl            = '0;
          ctl.idex_clear = 1'b1;
          ctl.exmem_load = 1'b1;
          ctl.memwb_load = 1'b1;
          stall_inc      = 1'b1;
        end else begin
          ctl = CTL_ADVANCE;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_busy) begin
          ctl            = CTL_FREEZE;
          ctl.ifid_clear = 1'b1;
          stall_inc      = 1'b1;
        end else begin
          ctl            = '0;
          ctl.ifid_clear = 1'b1;
          ctl.exmem_load = 1'b1;
          ctl.memwb_load = 1'b1;
          if (bus.ex_branch_taken) begin
            ctl.idex_clear = 1'b1;
            flush_inc      = 1'b1;
          end else begin
            ctl.idex_load = 1'b1;
          end
          if (drain_q == DrainW'(0)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q - DrainW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.CntW(CntW)) u_stall_cnt (
    .clk   (clock),
    .rst_n (clear_n),
    .clr_i (cnt_clr),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CntW(CntW)) u_flush_cnt (
    .clk   (clock),
    .rst_n (clear_n),
    .clr_i (cnt_clr),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

  assign bus.pc_load     = ctl.pc_load;
  assign bus.ifid_load   = ctl.ifid_load;
  assign bus.idex_load   = ctl.idex_load;
  assign bus.exmem_load  = ctl.exmem_load;
  assign bus.memwb_load  = ctl.memwb_load;
  assign bus.ifid_clear  = ctl.ifid_clear;
  assign bus.idex_clear  = ctl.idex_clear;
  assign bus.exmem_clear = ctl.exmem_clear;
  assign bus.memwb_clear = ctl.memwb_clear;
  assign bus.running     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done        = done_q;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one default instance plus a CntW=2 instance
// for counter saturation.
module tb_pipe_ctrl;

  logic clock;
  logic clear_n;
  int   n_chk;
  int   n_fail;

  pipe_ctrl_if                b0 ();
  pipe_ctrl_if #(.CntW(2))    b1 ();

  pipe_ctrl u0 (.clock(clock), .clear_n(clear_n), .bus(b0));
  pipe_ctrl #(.CntW(2)) u1 (.clock(clock), .clear_n(clear_n), .bus(b1));

  logic [4:0] ld0;
  logic [3:0] cl0;
  assign ld0 = {b0.pc_load, b0.ifid_load, b0.idex_load, b0.exmem_load, b0.memwb_load};
  assign cl0 = {b0.ifid_clear, b0.idex_clear, b0.exmem_clear, b0.memwb_clear};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    b0.start = 0; b0.halt = 0; b0.id_rs = 0; b0.id_rt = 0; b0.id_uses_rt = 0;
    b0.ex_mem_read = 0; b0.ex_rd = 0; b0.ex_branch_taken = 0; b0.mem_busy = 0;
    b1.start = 0; b1.halt = 0; b1.id_rs = 0; b1.id_rt = 0; b1.id_uses_rt = 0;
    b1.ex_mem_read = 0; b1.ex_rd = 0; b1.ex_branch_taken = 0; b1.mem_busy = 0;
  endtask

  task automatic set_hazard0();
    b0.ex_mem_read = 1; b0.ex_rd = 5'd5; b0.id_rs = 5'd5;
  endtask

  initial begin
    logic [31:0] sat_exp [5];
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    n_chk = 0;
    n_fail = 0;
    clear_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_loads", 32'(ld0), 32'h0);
    check("rst_clears", 32'(cl0), 32'hF);
    check("rst_running", 32'(b0.running), 32'h0);
    check("rst_done", 32'(b0.done), 32'h0);
    check("rst_stall", 32'(b0.stall_cnt), 32'h0);
    @(negedge clock);
    clear_n = 1'b1;
    b0.halt = 1;
    tick();
    check("idle_halt_ignored", 32'(b0.running), 32'h0);
    b0.halt = 0;
    b0.start = 1;
    #1;
    check("idle_clears", 32'(cl0), 32'hF);
    tick();
    b0.start = 0;
    check("start_running", 32'(b0.running), 32'h1);
    #1;
    check("run_loads", 32'(ld0), 32'h1F);
    check("run_clears", 32'(cl0), 32'h0);

    set_hazard0();
    #1;
    check("lu_loads", 32'(ld0), 32'h03);
    check("lu_clears", 32'(cl0), 32'h4);
    tick();
    idle_inputs();
    check("lu_stall", 32'(b0.stall_cnt), 32'h1);
    #1;
    check("lu_one_cycle", 32'(ld0), 32'h1F);

    b0.ex_mem_read = 1;
    #1;
    check("lu_r0_loads", 32'(ld0), 32'h1F);
    tick();
    check("lu_r0_stall", 32'(b0.stall_cnt), 32'h1);
    b0.ex_rd = 5'd7; b0.id_rt = 5'd7; b0.id_rs = 5'd3;
    #1;
    check("lu_rt_unused", 32'(ld0), 32'h1F);
    b0.id_uses_rt = 1;
    #1;
    check("lu_rt_used", 32'(ld0), 32'h03);
    tick();
    idle_inputs();
    check("lu_rt_stall", 32'(b0.stall_cnt), 32'h2);

    set_hazard0();
    b0.ex_branch_taken = 1;
    #1;
    check("br_lu_loads", 32'(ld0), 32'h13);
    check("br_lu_clears", 32'(cl0), 32'hC);
    tick();
    check("br_lu_flush", 32'(b0.flush_cnt), 32'h1);
    check("br_lu_stall", 32'(b0.stall_cnt), 32'h2);
    idle_inputs();

    b0.mem_busy = 1;
    b0.ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_loads", 32'(ld0), 32'h0);
      check("busy_clears", 32'(cl0), 32'h1);
      tick();
    end
    check("busy_stall", 32'(b0.stall_cnt), 32'h5);
    check("busy_flush", 32'(b0.flush_cnt), 32'h1);
    b0.mem_busy = 0;
    #1;
    check("busy_then_br_loads", 32'(ld0), 32'h13);
    tick();
    check("busy_then_br_flush", 32'(b0.flush_cnt), 32'h2);
    idle_inputs();

    set_hazard0();
    tick();
    tick();
    idle_inputs();
    check("pre_rst_stall", 32'(b0.stall_cnt), 32'h7);
    #2;
    clear_n = 1'b0;
    #1;
    check("midrst_loads", 32'(ld0), 32'h0);
    check("midrst_clears", 32'(cl0), 32'hF);
    check("midrst_stall", 32'(b0.stall_cnt), 32'h0);
    check("midrst_running", 32'(b0.running), 32'h0);
    @(negedge clock);
    clear_n = 1'b1;
    b0.start = 1;
    tick();
    b0.start = 0;
    check("restart_running", 32'(b0.running), 32'h1);

    b0.halt = 1;
    #1;
    check("halt_loads", 32'(ld0), 32'h07);
    check("halt_clears", 32'(cl0), 32'h8);
    tick();
    b0.halt = 0;
    check("drain_running", 32'(b0.running), 32'h1);
    #1;
    check("drain_loads", 32'(ld0), 32'h07);
    tick();
    check("drain_done_e1", 32'(b0.done), 32'h0);
    b0.mem_busy = 1;
    #1;
    check("drain_busy_loads", 32'(ld0), 32'h0);
    check("drain_busy_clears", 32'(cl0), 32'h9);
    tick();
    b0.mem_busy = 0;
    check("drain_done_e2", 32'(b0.done), 32'h0);
    check("drain_busy_stall", 32'(b0.stall_cnt), 32'h1);
    tick();
    check("drain_done_e3", 32'(b0.done), 32'h0);
    tick();
    check("drain_done_e4", 32'(b0.done), 32'h1);
    check("drain_idle_running", 32'(b0.running), 32'h0);
    check("drain_idle_clears", 32'(cl0), 32'hF);
    check("drain_idle_loads", 32'(ld0), 32'h0);
    tick();
    check("done_one_pulse", 32'(b0.done), 32'h0);

    b0.start = 1;
    tick();
    b0.start = 0;
    check("restart_flush", 32'(b0.flush_cnt), 32'h0);
    b0.halt = 1;
    tick();
    b0.halt = 0;
    b0.ex_branch_taken = 1;
    #1;
    check("drain_br_loads", 32'(ld0), 32'h03);
    check("drain_br_clears", 32'(cl0), 32'hC);
    tick();
    b0.ex_branch_taken = 0;
    check("drain_br_flush", 32'(b0.flush_cnt), 32'h1);
    tick();
    tick();
    check("drain_br_done", 32'(b0.done), 32'h1);

    b1.start = 1;
    tick();
    b1.start = 0;
    b1.ex_mem_read = 1; b1.ex_rd = 5'd5; b1.id_rs = 5'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_stall", 32'(b1.stall_cnt), sat_exp[i]);
    end
    b1.ex_mem_read = 0;
    b1.halt = 1;
    tick();
    b1.halt = 0;
    tick();
    tick();
    tick();
    check("sat_idle", 32'(b1.running), 32'h0);
    check("sat_hold_idle", 32'(b1.stall_cnt), 32'h3);
    b1.start = 1;
    tick();
    b1.start = 0;
    check("sat_start_clear", 32'(b1.stall_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage pipeline.
- Drives load/clear of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which all have synchronous active-high clear with priority over load.
- Handles start/halt, load-use stalls, taken-branch flushes and memory-busy freezes.
- Keeps saturating stall/flush statistics counters.

Parameters:
- RegAddrW, 5, register-specifier width.
- CntW, 16, width of stall_cnt and flush_cnt.
- DrainCycles, 3, non-busy cycles needed to empty ID/EX..MEM/WB after halt.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin execution.
- halt  in  1  stop fetching and drain the pipeline.
- id_rs  in  RegAddrW  source register A of instruction in ID.
- id_rt  in  RegAddrW  source register B of instruction in ID.
- id_uses_rt  in  1  instruction in ID reads id_rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  RegAddrW  destination register of instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_busy  in  1  data memory not ready this cycle.
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  register load enables.
- ifid_clear, idex_clear, exmem_clear, memwb_clear  out  1 each  register synchronous clears.
- running  out  1  state is RUN or DRAIN.
- done  out  1  registered one-cycle pulse on DRAIN->IDLE.
- stall_cnt  out  CntW  stall cycles since last start.
- flush_cnt  out  CntW  branch flushes since last start.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE, drain_cnt=0, done=0, stall_cnt=0, flush_cnt=0.
  - Outputs while reset is asserted equal the IDLE outputs.
- States: IDLE, RUN, DRAIN. Enable/clear outputs are combinational from state and inputs. State, counters and done are registered.
- IDLE outputs:
  - All loads=0, all clears=1, running=0.
  - start=1: next state RUN; stall_cnt and flush_cnt cleared to 0 on the same edge. halt is ignored.
- RUN: conditions are evaluated in fixed priority order; the first match applies.
  - 1. mem_busy=1 (freeze):
    - All loads=0; ifid/idex/exmem clears=0; memwb_clear=1 (bubble into WB).
    - stall_cnt+1.
    - halt/branch are ignored this cycle; the source holds them.
  - 2. halt=1:
    - pc_load=0, ifid_clear=1, other loads=1.
    - Next state DRAIN, drain_cnt=DrainCycles-1.
    - A simultaneous branch is dropped.
  - 3. ex_branch_taken=1:
    - pc_load=1, ifid_clear=1, idex_clear=1, exmem_load=1, memwb_load=1.
    - flush_cnt+1.
    - Overrides a concurrent load-use hazard; stall_cnt is not incremented.
  - 4. Load-use hazard, where hazard = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)):
    - pc_load=0, ifid_load=0, idex_clear=1, exmem_load=1, memwb_load=1.
    - stall_cnt+1.
  - 5. Otherwise: all loads=1, all clears=0.
- DRAIN:
  - pc_load=0, ifid_clear=1.
  - mem_busy=1: freeze as in RUN (memwb_clear=1, other ID/EX..MEM/WB loads=0), stall_cnt+1, drain_cnt holds.
  - Else if ex_branch_taken=1: idex_clear=1, exmem_load=1, memwb_load=1, flush_cnt+1.
  - Else: idex/exmem/memwb loads=1.
  - On each non-busy cycle: if drain_cnt==0, next state IDLE and done=1 next cycle; else drain_cnt-1.
  - halt and start are ignored; the load-use check is disabled.
- Counters saturate at 2^CntW-1.
- done is 0 in all cycles except the first IDLE cycle after DRAIN.
- A load and the clear of the same register are never both 1, except in IDLE, where all loads are 0.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2;
  - default RegAddrW and DrainCycles.
- One natural sub-module: sat_counter (CntW, synchronous clr, inc; saturating; async active-low reset), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset asserted mid-RUN with stall_cnt=7: all clears=1, loads=0, stall_cnt=0, running=0, immediately and without a clock edge. After release, start=1 gives running=1 on the next edge.
- RUN with ex_mem_read=1, ex_rd=5, id_rs=5: exactly one cycle of pc_load=0, ifid_load=0, idex_clear=1, stall_cnt 0->1. Repeat with ex_rd=0, id_rs=0: no stall.
- Same cycle ex_branch_taken=1 plus the load-use hazard above: pc_load=1, ifid_clear=1, idex_clear=1, flush_cnt 0->1, stall_cnt unchanged.
- mem_busy=1 for 3 cycles together with ex_branch_taken=1: all loads 0, memwb_clear=1, stall_cnt +3, flush_cnt unchanged. On the 4th cycle the flush takes effect.
- halt in RUN, then mem_busy=1 on the 2nd DRAIN cycle: done pulses exactly 5 cycles after the halt edge (1 halt + 3 drain + 1 busy). Then the IDLE outputs apply.
- CntW=2, 5 consecutive load-use stalls: stall_cnt reads 1,2,3,3,3. A following start from IDLE clears it to 0.
